fthread_wr_arbiter: RTL and testbench

//  Shares one fthread-controller write channel (tx_wr/rx_wr) between NUM_IF user write interfaces.
//  - Round-robin grant; requester index prepended to the outgoing tag.
//  - Write responses routed back to the owning interface by that index.
//  - Per-requester outstanding-write accounting, used for flow control and to drive an idle flag.
//  - Sits between the per-AFU write interfaces and the fthread controller's usr_arb_tx_wr/usr_arb_rx_wr ports.

---
 rtl/fthread_wr_arbiter_pkg.sv | 20 ++
 rtl/fthread_wr_arbiter_rr.sv | 94 +++++++++
 rtl/fthread_wr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fthread_wr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fthread_wr_arbiter_pkg.sv
// Shared constants, beat type and {idx, tag} pack/unpack macros for the fthread write arbiter.
// Build option: define WR_ARB_BURST_EN to enable burst-hold grants in fthread_wr_arbiter_rr.
`ifndef FTHREAD_WR_ARB_TAG_PACK
`define FTHREAD_WR_ARB_TAG_PACK(idx, tag) {(idx), (tag)}
`define FTHREAD_WR_ARB_TAG_IDX(ptag, tag_w, idx_w) ptag[(tag_w)+(idx_w)-1:(tag_w)]
`define FTHREAD_WR_ARB_TAG_USR(ptag, tag_w) ptag[(tag_w)-1:0]
`endif

package fthread_wr_arbiter_pkg;

    localparam int unsigned IF_TAG = 9;
    localparam int unsigned ADDR_W = 58;
    localparam int unsigned DATA_W = 512;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_beat_t;

endpackage

// File: rtl/fthread_wr_arbiter_rr.sv
// Round-robin arbiter: search starts at the entry after the last accepted grant.
// With WR_ARB_BURST_EN the last grantee keeps the grant for up to BURST_LEN accepts.
module fthread_wr_arbiter_rr #(
    parameter int unsigned NUM_IF    = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_IF-1:0] req_i,
    input  logic              advance_i,
    output logic [NUM_IF-1:0] grant_o,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              grant_valid_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;
    logic             hold;
    logic [IDX_W-1:0] hold_idx;

    // ptr_q is the search start, so the previous grantee sits just before it
    assign hold_idx = (ptr_q == '0) ? IDX_W'(NUM_IF - 1) : ptr_q - 1'b1;

`ifdef WR_ARB_BURST_EN
    localparam int unsigned BCNT_W = $clog2(BURST_LEN + 1);

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    assign hold = (bcnt_q != '0) && (32'(bcnt_q) < BURST_LEN) && req_i[hold_idx];

    always_comb begin
        bcnt_d = bcnt_q;
        if (advance_i && grant_valid_o) begin
            bcnt_d = hold ? bcnt_q + 1'b1 : BCNT_W'(1);
        end else if (!req_i[hold_idx]) begin
            bcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end
`else
    logic unused_burst_len;

    assign hold             = 1'b0;
    assign unused_burst_len = ^BURST_LEN;
`endif

    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = '0;
        for (int unsigned k = 0; k < NUM_IF; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NUM_IF);
            if (!grant_valid_o && req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
            end
        end
        if (hold) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = hold_idx;
        end
    end

    always_comb begin
        grant_o = '0;
        if (grant_valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && grant_valid_o) begin
            ptr_d = (32'(grant_idx_o) == NUM_IF - 1) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fthread_wr_arbiter.sv
// Shares one fthread-controller write channel between NUM_IF requesters with per-requester
// outstanding-write accounting. Build option: WR_ARB_BURST_EN (burst-hold grants).
module fthread_wr_arbiter
    import fthread_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_IF    = 4,
    parameter int unsigned TAG_W     = IF_TAG,
    parameter int unsigned IDX_W     = $clog2(NUM_IF),
    parameter int unsigned MAX_OUTST = 64,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_IF-1:0]        req_tx_wr_valid_i,
    input  logic [NUM_IF*ADDR_W-1:0] req_tx_wr_addr_i,
    input  logic [NUM_IF*TAG_W-1:0]  req_tx_wr_tag_i,
    input  logic [NUM_IF*DATA_W-1:0] req_tx_data_i,
    output logic [NUM_IF-1:0]        req_tx_wr_ready_o,
    output logic [NUM_IF-1:0]        req_rx_wr_valid_o,
    output logic [TAG_W-1:0]         req_rx_wr_tag_o,
    output logic [NUM_IF-1:0]        req_idle_o,
    output logic                     arb_tx_wr_valid_o,
    output logic [ADDR_W-1:0]        arb_tx_wr_addr_o,
    output logic [TAG_W+IDX_W-1:0]   arb_tx_wr_tag_o,
    output logic [DATA_W-1:0]        arb_tx_data_o,
    input  logic                     arb_tx_wr_ready_i,
    input  logic                     arb_rx_wr_valid_i,
    input  logic [TAG_W+IDX_W-1:0]   arb_rx_wr_tag_i,
    output logic                     err_spurious_rsp_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    logic [NUM_IF-1:0]      eligible;
    logic [NUM_IF-1:0]      grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic                   slot_free;
    logic                   accept;
    logic [NUM_IF-1:0]      rsp_hit;
    logic                   spurious;
    logic [IDX_W-1:0]       rx_idx;
    logic [IDX_W-1:0]       out_idx;

    logic [CNT_W-1:0]       outst_q [NUM_IF];
    logic [CNT_W-1:0]       outst_d [NUM_IF];
    logic                   out_valid_q, out_valid_d;
    wr_beat_t               out_beat_q, out_beat_d;
    logic [TAG_W+IDX_W-1:0] out_tag_q, out_tag_d;
    logic [NUM_IF-1:0]      rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0]       rsp_tag_q, rsp_tag_d;
    logic                   err_q, err_d;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_IF; i++) begin
            eligible[i] = req_tx_wr_valid_i[i] && (outst_q[i] != CNT_W'(MAX_OUTST));
        end
    end

    fthread_wr_arbiter_rr #(
        .NUM_IF    (NUM_IF),
        .IDX_W     (IDX_W),
        .BURST_LEN (BURST_LEN)
    ) u_rr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (eligible),
        .advance_i     (slot_free),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign slot_free         = ~out_valid_q | arb_tx_wr_ready_i;
    assign accept            = slot_free & grant_valid;
    assign req_tx_wr_ready_o = grant & {NUM_IF{slot_free}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        out_tag_d   = out_tag_q;
        if (accept) begin
            out_valid_d     = 1'b1;
            out_beat_d.addr = req_tx_wr_addr_i[32'(grant_idx)*ADDR_W +: ADDR_W];
            out_beat_d.data = req_tx_data_i[32'(grant_idx)*DATA_W +: DATA_W];
            out_tag_d       = `FTHREAD_WR_ARB_TAG_PACK(grant_idx,
                                  req_tx_wr_tag_i[32'(grant_idx)*TAG_W +: TAG_W]);
        end else if (arb_tx_wr_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    assign rx_idx  = `FTHREAD_WR_ARB_TAG_IDX(arb_rx_wr_tag_i, TAG_W, IDX_W);
    assign out_idx = `FTHREAD_WR_ARB_TAG_IDX(out_tag_q, TAG_W, IDX_W);

    // A response is only routed when its owner has something outstanding; anything else,
    // including an out-of-range index, is dropped and flagged.
    always_comb begin
        rsp_hit = '0;
        for (int unsigned i = 0; i < NUM_IF; i++) begin
            rsp_hit[i] = arb_rx_wr_valid_i && (rx_idx == IDX_W'(i)) && (outst_q[i] != '0);
        end
    end

    assign spurious = arb_rx_wr_valid_i & ~(|rsp_hit);

    always_comb begin
        rsp_valid_d = rsp_hit;
        rsp_tag_d   = (|rsp_hit) ? `FTHREAD_WR_ARB_TAG_USR(arb_rx_wr_tag_i, TAG_W) : rsp_tag_q;
        err_d       = err_q | spurious;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_IF; i++) begin
            outst_d[i] = outst_q[i];
            unique case ({accept && grant[i], rsp_hit[i]})
                2'b10:   outst_d[i] = outst_q[i] + 1'b1;
                2'b01:   outst_d[i] = outst_q[i] - 1'b1;
                default: outst_d[i] = outst_q[i];
            endcase
        end
    end

    always_comb begin
        req_idle_o = '0;
        for (int unsigned i = 0; i < NUM_IF; i++) begin
            req_idle_o[i] = (outst_q[i] == '0) && !req_tx_wr_valid_i[i] &&
                            !(out_valid_q && (out_idx == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_beat_q  <= '0;
            out_tag_q   <= '0;
            rsp_valid_q <= '0;
            rsp_tag_q   <= '0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_IF; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_beat_q  <= out_beat_d;
            out_tag_q   <= out_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            err_q       <= err_d;
            for (int unsigned i = 0; i < NUM_IF; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    assign arb_tx_wr_valid_o  = out_valid_q;
    assign arb_tx_wr_addr_o   = out_beat_q.addr;
    assign arb_tx_data_o      = out_beat_q.data;
    assign arb_tx_wr_tag_o    = out_tag_q;
    assign req_rx_wr_valid_o  = rsp_valid_q;
    assign req_rx_wr_tag_o    = rsp_tag_q;
    assign err_spurious_rsp_o = err_q;

endmodule

// File: tb/tb_fthread_wr_arbiter.sv
// Self-checking bench for fthread_wr_arbiter: vector table, hand-written corner sequences
// and a randomized run against a behavioural reference model.
module tb_fthread_wr_arbiter;

    localparam int NUM_IF = 4;
    localparam int TAG_W  = 9;
    localparam int IDX_W  = 2;
    localparam int MAXO   = 64;
    localparam int BLEN   = 4;
    localparam int AW     = 58;
    localparam int DW     = 512;
    localparam int PT_W   = TAG_W + IDX_W;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_IF-1:0]      valid;
    logic [NUM_IF*AW-1:0]   addr_bus;
    logic [NUM_IF*TAG_W-1:0] tag_bus;
    logic [NUM_IF*DW-1:0]   data_bus;
    logic [NUM_IF-1:0]      req_rdy;
    logic [NUM_IF-1:0]      rx_valid;
    logic [TAG_W-1:0]       rx_tag;
    logic [NUM_IF-1:0]      idle;
    logic                   arb_valid;
    logic [AW-1:0]          arb_addr;
    logic [PT_W-1:0]        arb_tag;
    logic [DW-1:0]          arb_data;
    logic                   rdy;
    logic                   rxv;
    logic [PT_W-1:0]        rxtag;
    logic                   err;

    logic [AW-1:0]    lane_addr [NUM_IF];
    logic [TAG_W-1:0] lane_tag  [NUM_IF];
    logic [DW-1:0]    lane_data [NUM_IF];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_IF; i++) begin
            addr_bus[i*AW +: AW]       = lane_addr[i];
            tag_bus[i*TAG_W +: TAG_W]  = lane_tag[i];
            data_bus[i*DW +: DW]       = lane_data[i];
        end
    end

    fthread_wr_arbiter #(
        .NUM_IF    (NUM_IF),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W),
        .MAX_OUTST (MAXO),
        .BURST_LEN (BLEN)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_tx_wr_valid_i  (valid),
        .req_tx_wr_addr_i   (addr_bus),
        .req_tx_wr_tag_i    (tag_bus),
        .req_tx_data_i      (data_bus),
        .req_tx_wr_ready_o  (req_rdy),
        .req_rx_wr_valid_o  (rx_valid),
        .req_rx_wr_tag_o    (rx_tag),
        .req_idle_o         (idle),
        .arb_tx_wr_valid_o  (arb_valid),
        .arb_tx_wr_addr_o   (arb_addr),
        .arb_tx_wr_tag_o    (arb_tag),
        .arb_tx_data_o      (arb_data),
        .arb_tx_wr_ready_i  (rdy),
        .arb_rx_wr_valid_i  (rxv),
        .arb_rx_wr_tag_i    (rxtag),
        .err_spurious_rsp_o (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    int               m_ptr;
    int               m_outst [NUM_IF];
    bit               m_sv;
    logic [AW-1:0]    m_saddr;
    logic [PT_W-1:0]  m_stag;
    logic [DW-1:0]    m_sdata;
    logic [NUM_IF-1:0] m_rv;
    logic [TAG_W-1:0] m_rtag;
    bit               m_err;
    int               m_hold;
    int               m_bcnt;

    task automatic m_reset();
        m_ptr = 0; m_sv = 0; m_saddr = '0; m_stag = '0; m_sdata = '0;
        m_rv = '0; m_rtag = '0; m_err = 0; m_hold = 0; m_bcnt = 0;
        for (int i = 0; i < NUM_IF; i++) m_outst[i] = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = '0; rdy = 1'b0; rxv = 1'b0; rxtag = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called at the negedge: checks DUT against model, then advances the model by one edge.
    task automatic model_cycle();
        bit               can;
        bit               found;
        int               g;
        int               ri;
        bit               routed;
        logic [NUM_IF-1:0] elig;
        logic [NUM_IF-1:0] exp_rdy;
        logic [NUM_IF-1:0] exp_idle;
        for (int i = 0; i < NUM_IF; i++) elig[i] = valid[i] && (m_outst[i] < MAXO);
        can = !m_sv || rdy;
        found = 0;
        g = 0;
`ifdef WR_ARB_BURST_EN
        if (m_bcnt > 0 && m_bcnt < BLEN && elig[m_hold]) begin
            found = 1;
            g = m_hold;
        end
`endif
        for (int k = 0; k < NUM_IF; k++) begin
            int c;
            c = (m_ptr + k) % NUM_IF;
            if (!found && elig[c]) begin
                found = 1;
                g = c;
            end
        end
        exp_rdy = (can && found) ? NUM_IF'(1 << g) : '0;
        for (int i = 0; i < NUM_IF; i++)
            exp_idle[i] = (m_outst[i] == 0) && !valid[i] && !(m_sv && m_stag[PT_W-1:TAG_W] == i);
        chk("rnd_req_ready", 64'(req_rdy), 64'(exp_rdy));
        chk("rnd_idle", 64'(idle), 64'(exp_idle));
        chk("rnd_arb_valid", 64'(arb_valid), 64'(m_sv));
        chk("rnd_arb_tag", 64'(arb_tag), 64'(m_stag));
        chk("rnd_arb_addr", 64'(arb_addr), 64'(m_saddr));
        chk("rnd_arb_data_eq", 64'(arb_data == m_sdata), 64'd1);
        chk("rnd_rx_valid", 64'(rx_valid), 64'(m_rv));
        chk("rnd_rx_tag", 64'(rx_tag), 64'(m_rtag));
        chk("rnd_err", 64'(err), 64'(m_err));
        // Advance
        ri = int'(rxtag[PT_W-1:TAG_W]);
        routed = rxv && (ri < NUM_IF) && (m_outst[ri] > 0);
        if (can && found) begin
            m_outst[g]++;
            m_sv = 1;
            m_saddr = lane_addr[g];
            m_sdata = lane_data[g];
            m_stag = {IDX_W'(g), lane_tag[g]};
            m_ptr = (g + 1) % NUM_IF;
            m_bcnt = (g == m_hold && m_bcnt > 0 && m_bcnt < BLEN) ? m_bcnt + 1 : 1;
            m_hold = g;
        end else begin
            if (rdy) m_sv = 0;
            if (!elig[m_hold]) m_bcnt = 0;
        end
        if (routed) begin
            m_outst[ri]--;
            m_rtag = rxtag[TAG_W-1:0];
        end
        m_rv = routed ? NUM_IF'(1 << ri) : '0;
        if (rxv && !routed) m_err = 1;
    endtask

    typedef struct packed {
        logic [NUM_IF-1:0] v;
        logic              rdy;
        logic [NUM_IF-1:0] exp_rdy;
        logic              exp_av;
        logic [IDX_W-1:0]  exp_idx;
    } vec_t;

    vec_t tbl [11];

    initial begin
        for (int i = 0; i < NUM_IF; i++) begin
            lane_addr[i] = AW'(58'h100_0000 + i * 64);
            lane_tag[i]  = TAG_W'(9'h0A0 + i);
            lane_data[i] = {32'hDA7A_0000 + 32'(i), 448'd0, 32'(i)};
        end
        tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[4]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[5]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[6]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[7]  = '{4'h4, 1'b1, 4'b0100, 1'b1, 2'd0};
        tbl[8]  = '{4'h4, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[9]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[10] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_arb_valid", 64'(arb_valid), 64'd0);
        chk("rst_arb_tag", 64'(arb_tag), 64'd0);
        chk("rst_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_rx_tag", 64'(rx_tag), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_idle", 64'(idle), 64'hF);
        chk("rst_req_ready", 64'(req_rdy), 64'd0);

`ifndef WR_ARB_BURST_EN
        // Round-robin order, 1-cycle latency and backpressure hold
        tick();
        for (int k = 0; k < 11; k++) begin
            valid = tbl[k].v;
            rdy   = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_req_ready", k), 64'(req_rdy), 64'(tbl[k].exp_rdy));
            chk($sformatf("tbl%0d_arb_valid", k), 64'(arb_valid), 64'(tbl[k].exp_av));
            if (tbl[k].exp_av)
                chk($sformatf("tbl%0d_arb_tag", k), 64'(arb_tag),
                    64'({tbl[k].exp_idx, lane_tag[tbl[k].exp_idx]}));
            tick();
        end
`else
        // Burst grant pattern with two requesters
        begin
            int exp_g [8];
            exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
            do_reset();
            valid = 4'b0011;
            rdy = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk($sformatf("burst%0d_req_ready", k), 64'(req_rdy), 64'(1 << exp_g[k]));
                tick();
            end
        end
`endif

        // Requester 2 saturates at MAX outstanding, then one response reopens it
        do_reset();
        valid = 4'b0100;
        rdy = 1'b1;
        repeat (MAXO) tick();
        @(negedge clk);
        chk("sat_req_ready_masked", 64'(req_rdy), 64'd0);
        chk("sat_arb_valid_last", 64'(arb_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("sat_arb_valid_drained", 64'(arb_valid), 64'd0);
        rxv = 1'b1;
        rxtag = {2'd2, 9'h015};
        tick();
        rxv = 1'b0;
        @(negedge clk);
        chk("sat_rx_valid", 64'(rx_valid), 64'b0100);
        chk("sat_rx_tag", 64'(rx_tag), 64'h015);
        chk("sat_req_ready_reopen", 64'(req_rdy), 64'b0100);
        chk("sat_err", 64'(err), 64'd0);

        // Same-cycle accept and response on requester 1 leaves the count unchanged
        do_reset();
        valid = 4'b0010;
        rdy = 1'b1;
        tick();
        rxv = 1'b1;
        rxtag = {2'd1, 9'h033};
        tick();
        valid = '0;
        rxv = 1'b0;
        @(negedge clk);
        chk("same_rx_valid", 64'(rx_valid), 64'b0010);
        chk("same_rx_tag", 64'(rx_tag), 64'h033);
        chk("same_idle1_slot", 64'(idle[1]), 64'd0);
        tick();
        @(negedge clk);
        chk("same_idle1_outst", 64'(idle[1]), 64'd0);
        rxv = 1'b1;
        rxtag = {2'd1, 9'h034};
        tick();
        rxv = 1'b0;
        @(negedge clk);
        chk("same_idle1_done", 64'(idle[1]), 64'd1);

        // Spurious response is dropped and latches the sticky error until reset
        do_reset();
        rxv = 1'b1;
        rxtag = {2'd3, 9'h1FF};
        tick();
        rxv = 1'b0;
        @(negedge clk);
        chk("spur_rx_valid", 64'(rx_valid), 64'd0);
        chk("spur_err", 64'(err), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("spur_err_sticky", 64'(err), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("spur_err_cleared", 64'(err), 64'd0);

        // Asynchronous reset in the middle of traffic clears registered outputs at once
        do_reset();
        valid = 4'hF;
        rdy = 1'b1;
        repeat (3) tick();
        rxv = 1'b1;
        rxtag = {2'd0, 9'h077};
        tick();
        rxv = 1'b0;
        @(negedge clk);
        chk("arst_pre_arb_valid", 64'(arb_valid), 64'd1);
        chk("arst_pre_rx_valid", 64'(rx_valid), 64'b0001);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_arb_valid", 64'(arb_valid), 64'd0);
        chk("arst_arb_tag", 64'(arb_tag), 64'd0);
        chk("arst_arb_addr", 64'(arb_addr), 64'd0);
        chk("arst_rx_valid", 64'(rx_valid), 64'd0);
        chk("arst_rx_tag", 64'(rx_tag), 64'd0);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int s;
            int pick;
            valid = NUM_IF'($urandom);
            rdy = ($urandom_range(3) != 0);
            for (int i = 0; i < NUM_IF; i++) begin
                lane_addr[i] = {26'($urandom), $urandom};
                lane_tag[i]  = TAG_W'($urandom);
                lane_data[i] = {$urandom, 448'd0, $urandom};
            end
            rxv = 1'b0;
            if ($urandom_range(2) == 0) begin
                s = $urandom_range(NUM_IF - 1);
                pick = -1;
                for (int k = 0; k < NUM_IF; k++)
                    if (pick < 0 && m_outst[(s + k) % NUM_IF] > 0) pick = (s + k) % NUM_IF;
                if ($urandom_range(39) == 0) pick = s;
                if (pick >= 0) begin
                    rxv = 1'b1;
                    rxtag = {IDX_W'(pick), TAG_W'($urandom)};
                end
            end
            @(negedge clk);
            model_cycle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
